// File: rtl/compute_cluster_pkg.sv
// Shared compute-cluster definitions used by the output-buffer drain slice.
//   - default cluster geometry (compute units, output buffers, buffer word width)
//   - drain_state_e : drain FSM states
//   - out_beat_t    : stream beat layout {last, data} as held in the drain FIFO
//   - sel_width()   : select width that never collapses to zero bits
package compute_cluster_pkg;

    localparam int unsigned COMPUTE_UNIT_NUM = 2;
    localparam int unsigned OUTPUT_BUF_NUM   = 4;
    localparam int unsigned OUTPUT_BUF_SIZE  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } drain_state_e;

    typedef struct packed {
        logic                       last;
        logic [OUTPUT_BUF_SIZE-1:0] data;
    } out_beat_t;

    // A single unit/buffer still needs a 1-bit select port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_buf_drain_if.sv
// Output-buffer read port plus the write-back stream, bundled as one interface.
//   master : the drain (drives selects, stream data/valid/last, optional clear)
//   slave  : buffer array + stream sink (drives buffer data and stream ready)
// Signals:
//   com_unit_out_buf_sel_o / out_buf_sel_o : registered read address
//   out_buf_dat_i                          : read data, one cycle after the address
//   out_dat_o / out_valid_o / out_last_o   : stream beat
//   out_ready_i                            : stream back-pressure
//   out_buf_clr_o                          : buffer clear pulse (OUT_BUF_CLEAR_EN only)
interface out_buf_drain_if
    import compute_cluster_pkg::*;
#(
    parameter int unsigned CU_NUM  = COMPUTE_UNIT_NUM,
    parameter int unsigned BUF_NUM = OUTPUT_BUF_NUM,
    parameter int unsigned DAT_W   = OUTPUT_BUF_SIZE
);

    localparam int unsigned CuSelW  = sel_width(CU_NUM);
    localparam int unsigned BufSelW = sel_width(BUF_NUM);

    logic [CuSelW-1:0]  com_unit_out_buf_sel_o;
    logic [BufSelW-1:0] out_buf_sel_o;
    logic [DAT_W-1:0]   out_buf_dat_i;
    logic [DAT_W-1:0]   out_dat_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               out_last_o;
`ifdef OUT_BUF_CLEAR_EN
    logic               out_buf_clr_o;
`endif

    modport master (
`ifdef OUT_BUF_CLEAR_EN
        output out_buf_clr_o,
`endif
        output com_unit_out_buf_sel_o,
        output out_buf_sel_o,
        input  out_buf_dat_i,
        output out_dat_o,
        output out_valid_o,
        input  out_ready_i,
        output out_last_o
    );

    modport slave (
`ifdef OUT_BUF_CLEAR_EN
        input  out_buf_clr_o,
`endif
        input  com_unit_out_buf_sel_o,
        input  out_buf_sel_o,
        output out_buf_dat_i,
        input  out_dat_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_last_o
    );

endinterface

// File: rtl/out_drain_fifo.sv
// Two-entry FIFO holding returned buffer words until the stream accepts them.
// The head entry is read straight from storage registers, so a word pushed
// into an empty FIFO becomes visible the cycle after the push (no fall-through).
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   push_i, data_i  : write strobe and word
//   pop_i           : consume the head entry
//   data_o          : head entry
//   count_o         : occupancy, 0..2
// Overflow/underflow are prevented by the caller.
module out_drain_fifo
    import compute_cluster_pkg::*;
#(
    parameter int unsigned Width = $bits(out_beat_t)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/out_buf_drain.sv
// Drains the compute cluster's output buffers after a layer pass: walks the
// (compute unit, buffer) address space CU-major, captures each returned word
// one cycle after its address and streams the words out on valid/ready, with
// a last tag on the final beat.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   drain_start_i  : start pulse, ignored unless idle
//   buf_num_i      : used buffers per compute unit, sampled at start
//   drain_busy_o   : drain in progress
//   drain_done_o   : one-cycle completion pulse
//   bus            : buffer read port + output stream (master side)
// Build option: OUT_BUF_CLEAR_EN adds a buffer clear pulse after each read and
// halves the drain rate, because the selects must stay on the read address
// for the clear cycle.
module out_buf_drain
    import compute_cluster_pkg::*;
#(
    parameter int unsigned CU_NUM  = COMPUTE_UNIT_NUM,
    parameter int unsigned BUF_NUM = OUTPUT_BUF_NUM,
    parameter int unsigned DAT_W   = OUTPUT_BUF_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         drain_start_i,
    input  logic [$clog2(BUF_NUM+1)-1:0] buf_num_i,
    output logic                         drain_busy_o,
    output logic                         drain_done_o,
    out_buf_drain_if.master              bus
);

    localparam int unsigned CuSelW  = sel_width(CU_NUM);
    localparam int unsigned BufSelW = sel_width(BUF_NUM);
    localparam int unsigned BufNumW = $clog2(BUF_NUM + 1);
    localparam logic [CuSelW-1:0] CuLast = CuSelW'(CU_NUM - 1);

    drain_state_e       state_q, state_d;
    logic [BufNumW-1:0] buf_num_q, buf_num_d;
    logic [CuSelW-1:0]  cu_sel_q, cu_sel_d;
    logic [BufSelW-1:0] buf_sel_q, buf_sel_d;
    logic               inflight_q;
    logic               inflight_last_q;

    logic [1:0]         fifo_count;
    logic [DAT_W:0]     fifo_head;
    logic               out_valid;
    logic               out_last;
    logic               pop;
    logic               buf_wrap;
    logic               last_addr;
    logic               credit_ok;
    logic               issue;
    logic               advance;

    assign out_valid = (fifo_count != 2'd0);
    assign out_last  = out_valid && fifo_head[DAT_W];
    assign pop       = out_valid && bus.out_ready_i;

    assign buf_wrap  = (BufNumW'(buf_sel_q) == (buf_num_q - BufNumW'(1)));
    assign last_addr = buf_wrap && (cu_sel_q == CuLast);

    // Slots already claimed (stored + in flight) minus the one leaving this
    // cycle must leave room, so every returned word has a FIFO entry waiting.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

`ifdef OUT_BUF_CLEAR_EN
    logic clr_q;

    // Selects advance only after the clear cycle of each read.
    assign issue   = (state_q == StIssue) && credit_ok && !clr_q;
    assign advance = clr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= issue;
        end
    end

    assign bus.out_buf_clr_o = clr_q;
`else
    assign issue   = (state_q == StIssue) && credit_ok;
    assign advance = issue;
`endif

    always_comb begin
        state_d   = state_q;
        buf_num_d = buf_num_q;
        cu_sel_d  = cu_sel_q;
        buf_sel_d = buf_sel_q;
        case (state_q)
            StIdle: begin
                if (drain_start_i) begin
                    buf_num_d = buf_num_i;
                    cu_sel_d  = '0;
                    buf_sel_d = '0;
                    state_d   = (buf_num_i == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (advance) begin
                    if (last_addr) begin
                        // Park the selects at (0,0) once the whole space is read.
                        cu_sel_d  = '0;
                        buf_sel_d = '0;
                        state_d   = StFlush;
                    end else if (buf_wrap) begin
                        buf_sel_d = '0;
                        cu_sel_d  = cu_sel_q + CuSelW'(1);
                    end else begin
                        buf_sel_d = buf_sel_q + BufSelW'(1);
                    end
                end
            end
            StFlush: begin
                if (pop && out_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            buf_num_q       <= '0;
            cu_sel_q        <= '0;
            buf_sel_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_num_q       <= buf_num_d;
            cu_sel_q        <= cu_sel_d;
            buf_sel_q       <= buf_sel_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_addr;
        end
    end

    // Word for an issued address arrives one cycle later; capture it with its tag.
    out_drain_fifo #(
        .Width (DAT_W + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .data_i  ({inflight_last_q, bus.out_buf_dat_i}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign bus.com_unit_out_buf_sel_o = cu_sel_q;
    assign bus.out_buf_sel_o          = buf_sel_q;
    assign bus.out_valid_o            = out_valid;
    assign bus.out_last_o             = out_last;
    assign bus.out_dat_o              = out_valid ? fifo_head[DAT_W-1:0] : '0;

    assign drain_busy_o = (state_q == StIssue) || (state_q == StFlush);
    assign drain_done_o = (state_q == StDone);

endmodule

// File: tb/tb_out_buf_drain.sv
// Directed bench for out_buf_drain: CU_NUM=2, BUF_NUM=4, 16-bit words, and a
// registered buffer model returning (cu << 8 | buf) one cycle after the select.
// Build with OUT_BUF_CLEAR_EN defined to cover the buffer-clear variant.
module tb_out_buf_drain;
    import compute_cluster_pkg::*;

    localparam int unsigned CuN  = 2;
    localparam int unsigned BufN = 4;
    localparam int unsigned DatW = 16;
`ifdef OUT_BUF_CLEAR_EN
    localparam int Gap = 2;
`else
    localparam int Gap = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drain_start = 1'b0;
    logic [2:0] buf_num = 3'd0;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [15:0] got_dat  [16];
    logic        got_last [16];
    int          got_k    [16];
    int          clr_k    [16];
    int got_n, done_n, done_k, first_k, stall_viol, clr_n, clr_bad;

    out_buf_drain_if #(.CU_NUM(CuN), .BUF_NUM(BufN), .DAT_W(DatW)) bus ();

    out_buf_drain #(
        .CU_NUM  (CuN),
        .BUF_NUM (BufN),
        .DAT_W   (DatW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .drain_start_i (drain_start),
        .buf_num_i     (buf_num),
        .drain_busy_o  (busy),
        .drain_done_o  (done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Buffer array model: registered read of (cu << 8 | buf).
    always @(posedge clk)
        bus.out_buf_dat_i <= {7'b0, bus.com_unit_out_buf_sel_o, 6'b0, bus.out_buf_sel_o};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_dat(input int i);
        return 16'(((i / 3) << 8) | (i % 3));
    endfunction

    function automatic logic [2:0] exp_sel(input int i);
        return 3'(((i / 3) << 2) | (i % 3));
    endfunction

    // Called at posedge+1; leaves time at posedge+1 just after the accepting edge.
    task automatic pulse_start(input logic [2:0] n);
        buf_num     = n;
        drain_start = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
    endtask

    // Runs the stream side of a drain and records beats, done pulses and clears.
    task automatic run_drain(input bit rnd, input int restart_at);
        bit          stalled;
        logic [15:0] pd;
        logic        pl;
        got_n = 0; done_n = 0; done_k = -1; first_k = -1;
        stall_viol = 0; clr_n = 0; clr_bad = 0;
        stalled = 1'b0; pd = '0; pl = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (stalled && (!bus.out_valid_o || bus.out_dat_o !== pd || bus.out_last_o !== pl))
                stall_viol++;
            if (bus.out_valid_o && first_k < 0) first_k = k;
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
`ifdef OUT_BUF_CLEAR_EN
            if (bus.out_buf_clr_o) begin
                if (clr_n < 16) begin
                    clr_k[clr_n] = k;
                    if ({bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o} !== exp_sel(clr_n))
                        clr_bad++;
                end
                clr_n++;
            end
`endif
            bus.out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drain_start     = (k == restart_at);
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (got_n < 16) begin
                    got_dat[got_n]  = bus.out_dat_o;
                    got_last[got_n] = bus.out_last_o;
                    got_k[got_n]    = k;
                end
                got_n++;
            end
            stalled = bus.out_valid_o && !bus.out_ready_i;
            pd      = bus.out_dat_o;
            pl      = bus.out_last_o;
            if (done_k > 0 && k >= done_k + 3) break;
        end
        bus.out_ready_i = 1'b1;
        drain_start     = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({busy, done, bus.out_valid_o, bus.out_last_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {busy, done, bus.out_valid_o, bus.out_last_o});
        end
        tests++;
        if (bus.out_dat_o !== 16'h0000) begin
            fails++;
            $display("FAIL reset_dat: got %h want 0000", bus.out_dat_o);
        end
        tests++;
        if ({bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_sel: got %b want 000",
                     {bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({busy, done, bus.out_valid_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_release: got %b want 000", {busy, done, bus.out_valid_o});
        end
    endtask

    task automatic test_full_rate();
        pulse_start(3'd3);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL full_busy: got %b want 1", busy);
        end
        tests++;
        if ({bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o} !== 3'b000) begin
            fails++;
            $display("FAIL full_sel0: got %b want 000",
                     {bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o});
        end
        run_drain(1'b0, -1);
        tests++;
        if (first_k !== 2) begin
            fails++;
            $display("FAIL full_first_valid: got cycle %0d want 2", first_k);
        end
        tests++;
        if (got_n !== 6) begin
            fails++;
            $display("FAIL full_beats: got %0d want 6", got_n);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_dat[i] !== exp_dat(i) || got_last[i] !== (i == 5) || got_k[i] !== 2 + Gap * i)
            begin
                fails++;
                $display("FAIL full_beat%0d: got %h last %b cycle %0d want %h last %b cycle %0d",
                         i, got_dat[i], got_last[i], got_k[i], exp_dat(i), (i == 5), 2 + Gap * i);
            end
        end
        tests++;
        if (done_n !== 1 || done_k !== 3 + Gap * 5) begin
            fails++;
            $display("FAIL full_done: got %0d pulses at %0d want 1 at %0d",
                     done_n, done_k, 3 + Gap * 5);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL full_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        pulse_start(3'd3);
        run_drain(1'b1, -1);
        tests++;
        if (got_n !== 6) begin
            fails++;
            $display("FAIL stall_beats: got %0d want 6", got_n);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_dat[i] !== exp_dat(i) || got_last[i] !== (i == 5)) begin
                fails++;
                $display("FAIL stall_beat%0d: got %h last %b want %h last %b",
                         i, got_dat[i], got_last[i], exp_dat(i), (i == 5));
            end
        end
        tests++;
        if (stall_viol !== 0) begin
            fails++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol);
        end
        tests++;
        if (done_n !== 1) begin
            fails++;
            $display("FAIL stall_done: got %0d pulses want 1", done_n);
        end
    endtask

    task automatic test_zero_bufs();
        int valid_n;
        int done_late;
        int sel_bad;
        valid_n = 0; done_late = 0; sel_bad = 0;
        pulse_start(3'd0);
        tests++;
        if ({done, busy} !== 2'b10) begin
            fails++;
            $display("FAIL zero_done: got done,busy %b want 10", {done, busy});
        end
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid_o) valid_n++;
            if (k > 0 && done) done_late++;
            if ({bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o} !== 3'b000) sel_bad++;
            @(posedge clk); #1;
        end
        tests++;
        if (valid_n !== 0 || done_late !== 0 || sel_bad !== 0) begin
            fails++;
            $display("FAIL zero_quiet: got valid %0d extra done %0d sel moves %0d want 0 0 0",
                     valid_n, done_late, sel_bad);
        end
    endtask

    task automatic test_restart_ignored();
        pulse_start(3'd3);
        run_drain(1'b0, 2 + Gap * 2);
        tests++;
        if (got_n !== 6 || done_n !== 1) begin
            fails++;
            $display("FAIL restart_count: got %0d beats %0d done want 6 beats 1 done",
                     got_n, done_n);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_dat[i] !== exp_dat(i)) begin
                fails++;
                $display("FAIL restart_beat%0d: got %h want %h", i, got_dat[i], exp_dat(i));
            end
        end
        // A second drain must still be accepted afterwards.
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int resumed;
        resumed = 0;
        pulse_start(3'd3);
        for (int k = 1; k <= 2 + Gap; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, bus.out_valid_o, bus.out_last_o} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_ctrl: got %b want 0000",
                     {busy, done, bus.out_valid_o, bus.out_last_o});
        end
        tests++;
        if (bus.out_dat_o !== 16'h0000 ||
            {bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_dat_sel: got %h sel %b want 0000 sel 000", bus.out_dat_o,
                     {bus.com_unit_out_buf_sel_o, bus.out_buf_sel_o});
        end
`ifdef OUT_BUF_CLEAR_EN
        tests++;
        if (bus.out_buf_clr_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_clr: got %b want 0", bus.out_buf_clr_o);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid_o || busy) resumed++;
        end
        tests++;
        if (resumed !== 0) begin
            fails++;
            $display("FAIL midrst_resume: got %0d active cycles want 0", resumed);
        end
        pulse_start(3'd3);
        run_drain(1'b0, -1);
        tests++;
        if (got_n !== 6 || first_k !== 2) begin
            fails++;
            $display("FAIL midrst_redrain: got %0d beats first at %0d want 6 at 2",
                     got_n, first_k);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_dat[i] !== exp_dat(i)) begin
                fails++;
                $display("FAIL midrst_beat%0d: got %h want %h", i, got_dat[i], exp_dat(i));
            end
        end
    endtask

`ifdef OUT_BUF_CLEAR_EN
    task automatic test_clear();
        pulse_start(3'd3);
        run_drain(1'b0, -1);
        tests++;
        if (clr_n !== 6 || clr_bad !== 0) begin
            fails++;
            $display("FAIL clear_pulses: got %0d pulses %0d bad selects want 6 and 0",
                     clr_n, clr_bad);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (clr_k[i] !== 1 + 2 * i) begin
                fails++;
                $display("FAIL clear_timing%0d: got cycle %0d want %0d", i, clr_k[i], 1 + 2 * i);
            end
        end
    endtask
`endif

    initial begin
        bus.out_ready_i = 1'b1;
        test_reset();
        test_full_rate();
        test_stall();
        test_zero_bufs();
        test_restart_ignored();
        test_reset_mid();
`ifdef OUT_BUF_CLEAR_EN
        test_clear();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
